// File: rtl/proc_ctrl_pkg.sv
// Shared types for the processor execution controller.
package proc_ctrl_pkg;

   // Controller states. The encoding is shown directly on the board LEDs.
   typedef enum logic [1:0] {
      HALT = 2'd0,
      STEP = 2'd1,
      RUN  = 2'd2,
      BRK  = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: a 2-FF synchronizer, then a debouncer that accepts a
// new level only after DEBOUNCE_CYCLES consecutive samples that differ from
// the accepted level. It emits a one-cycle press pulse on an accepted 0->1 edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             press_q;
   logic             press_d;

   // Bring the raw asynchronous button into the clock domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Count differing samples; any sample equal to the accepted level restarts
   // the count, so bouncing never reaches the acceptance threshold.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         level_d = sync2_q;
         press_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state and the registered press pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/proc_step_ctrl.sv
// Execution controller for the single-cycle core: generates a one-cycle clock
// enable for halt, single-step, slow continuous run and PC breakpoint modes.
module proc_step_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int RATE_DIV        = 5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_step,
   input  logic        btn_run,
   input  logic        brk_en,
   input  logic [31:0] brk_pc,
   input  logic [31:0] pc,
   output logic        cpu_en,
   output logic        halted,
   output logic        at_brk,
   output logic [1:0]  state,
   output logic [31:0] instr_count
);

   localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RATE_DIV - 1);

   ctrl_state_t       state_q;
   ctrl_state_t       state_d;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_d;
   logic              skip_q;
   logic              skip_d;
   logic [31:0]       instr_count_q;
   logic [31:0]       instr_count_d;
   logic              issue_en;
   logic              step_press;
   logic              run_press;
   logic              tick;
   logic              brk_hit;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_step),
      .press_o (step_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_run),
      .press_o (run_press)
   );

   assign tick    = (state_q == RUN) && (div_q == DIV_MAX);
   assign brk_hit = brk_en && (pc == brk_pc) && !skip_q;

   // Next-state logic. The divider only advances in RUN and sits at zero
   // elsewhere, so every RUN entry starts a fresh period. Run presses beat
   // step presses and also beat a coinciding tick or breakpoint.
   always_comb begin
      state_d       = state_q;
      div_d         = '0;
      skip_d        = skip_q;
      issue_en      = 1'b0;
      unique case (state_q)
         HALT: begin
            if (run_press) begin
               state_d = RUN;
            end else if (step_press) begin
               state_d = STEP;
            end
         end
         STEP: begin
            issue_en = 1'b1;
            state_d  = HALT;
         end
         RUN: begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (run_press) begin
               state_d = HALT;
            end else if (tick) begin
               if (brk_hit) begin
                  state_d = BRK;
               end else begin
                  issue_en = 1'b1;
                  skip_d   = 1'b0;
               end
            end
         end
         BRK: begin
            if (run_press) begin
               state_d = RUN;
               skip_d  = 1'b1;
            end else if (step_press) begin
               state_d = STEP;
            end
         end
         default: state_d = HALT;
      endcase
      instr_count_d = issue_en ? instr_count_q + 32'd1 : instr_count_q;
   end

   // Architectural controller state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= HALT;
         div_q         <= '0;
         skip_q        <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         skip_q        <= skip_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign cpu_en      = issue_en;
   assign halted      = (state_q != RUN);
   assign at_brk      = (state_q == BRK);
   assign state       = state_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_proc_step_ctrl.sv
// Directed self-checking bench for proc_step_ctrl (DEBOUNCE_CYCLES=4, RATE_DIV=3).
module tb_proc_step_ctrl;

   localparam int DEB  = 4;
   localparam int RDIV = 3;
   localparam logic [1:0] stHalt = 2'd0;
   localparam logic [1:0] stStep = 2'd1;
   localparam logic [1:0] stRun  = 2'd2;
   localparam logic [1:0] stBrk  = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        btnStep = 1'b0;
   logic        btnRun = 1'b0;
   logic        brkEn = 1'b0;
   logic [31:0] brkPc = 32'h10;
   logic [31:0] pc = 32'h100;
   logic        cpuEn;
   logic        halted;
   logic        atBrk;
   logic [1:0]  stateO;
   logic [31:0] instrCount;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulses = 0;
   int consec = 0;
   bit lastEn = 1'b0;
   bit pcTrack = 1'b0;

   proc_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .RATE_DIV(RDIV)) dut (
      .clk         (clock),
      .reset       (reset),
      .btn_step    (btnStep),
      .btn_run     (btnRun),
      .brk_en      (brkEn),
      .brk_pc      (brkPc),
      .pc          (pc),
      .cpu_en      (cpuEn),
      .halted      (halted),
      .at_brk      (atBrk),
      .state       (stateO),
      .instr_count (instrCount)
   );

   // Free-running 100 MHz-equivalent simulation clock.
   always #5 clock = ~clock;

   // Advance one cycle; the processor model moves pc after each enable.
   task automatic stepCycle();
      @(negedge clock);
      if (pcTrack && lastEn) pc = (pc + 32'd4) & 32'h1F;
      #1;
      if (cpuEn && lastEn) consec++;
      lastEn = cpuEn;
      cyc++;
      if (cpuEn) pulses++;
   endtask

   task automatic waitState(input logic [1:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         stepCycle();
         if (stateO === s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic doReset();
      reset   = 1'b1;
      btnStep = 1'b0;
      btnRun  = 1'b0;
      pcTrack = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      lastEn = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL reset_state got=%0d want=%0d", stateO, stHalt); end
      checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_en got=%b want=0", cpuEn); end
      checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL reset_halted got=%b want=1", halted); end
      checks++; if (atBrk !== 1'b0) begin failures++; $display("[TB] FAIL reset_at_brk got=%b want=0", atBrk); end
      checks++; if (instrCount !== 32'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", instrCount); end
   endtask

   task automatic test_bounce();
      int p0;
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         btnStep = ~btnStep;
         stepCycle();
         stepCycle();
      end
      btnStep = 1'b1;
      repeat (10) stepCycle();
      btnStep = 1'b0;
      repeat (10) stepCycle();
      checks++; if (pulses - p0 != 1) begin failures++; $display("[TB] FAIL bounce_pulses got=%0d want=1", pulses - p0); end
      checks++; if (instrCount !== 32'd1) begin failures++; $display("[TB] FAIL bounce_count got=%0d want=1", instrCount); end
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL bounce_state got=%0d want=%0d", stateO, stHalt); end
   endtask

   task automatic test_run_cadence();
      bit ok;
      bit stopEn;
      int entry;
      int p0;
      brkEn = 1'b0;
      pc    = 32'h100;
      btnRun = 1'b1;
      waitState(stRun, 20, ok);
      entry = cyc;
      btnRun = 1'b0;
      checks++; if (!ok) begin failures++; $display("[TB] FAIL cadence_enter got=%0d want=%0d", stateO, stRun); end
      for (int off = 0; off < 9; off++) begin
         if (off > 0) stepCycle();
         checks++;
         if (cpuEn !== ((off % RDIV) == RDIV - 1)) begin
            failures++;
            $display("[TB] FAIL cadence_off%0d got=%b want=%b", off, cpuEn, (off % RDIV) == RDIV - 1);
         end
      end
      while ((cyc - entry) % RDIV != 0) stepCycle();
      btnRun = 1'b1;
      stopEn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stopEn = cpuEn;
         stepCycle();
         if (stateO !== stRun) break;
      end
      btnRun = 1'b0;
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL cadence_stop got=%0d want=%0d", stateO, stHalt); end
      checks++; if (stopEn !== 1'b0) begin failures++; $display("[TB] FAIL cadence_stop_en got=%b want=0", stopEn); end
      p0 = pulses;
      repeat (10) stepCycle();
      checks++; if (pulses != p0) begin failures++; $display("[TB] FAIL cadence_quiet got=%0d want=%0d", pulses, p0); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      bit stopEn;
      int entry;
      int stopCyc;
      int p0;
      doReset();
      p0 = pulses;
      btnStep = 1'b1;
      btnRun  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (stateO !== stHalt) begin
            ok = 1'b1;
            break;
         end
      end
      entry = cyc;
      btnStep = 1'b0;
      btnRun  = 1'b0;
      checks++; if (!ok || stateO !== stRun) begin failures++; $display("[TB] FAIL simul_state got=%0d want=%0d", stateO, stRun); end
      checks++; if (pulses != p0) begin failures++; $display("[TB] FAIL simul_no_step got=%0d want=%0d", pulses, p0); end
      repeat (8) stepCycle();
      while ((cyc - entry) % RDIV != RDIV - 1) stepCycle();
      btnRun = 1'b1;
      stopEn = 1'b0;
      stopCyc = cyc;
      for (int i = 0; i < 20; i++) begin
         stopEn  = cpuEn;
         stopCyc = cyc;
         stepCycle();
         if (stateO !== stRun) break;
      end
      btnRun = 1'b0;
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL tickstop_state got=%0d want=%0d", stateO, stHalt); end
      checks++; if ((stopCyc - entry) % RDIV != RDIV - 1) begin failures++; $display("[TB] FAIL tickstop_phase got=%0d want=%0d", (stopCyc - entry) % RDIV, RDIV - 1); end
      checks++; if (stopEn !== 1'b0) begin failures++; $display("[TB] FAIL tickstop_en got=%b want=0", stopEn); end
      repeat (10) stepCycle();
   endtask

   task automatic test_breakpoint();
      bit ok;
      doReset();
      pcTrack = 1'b1;
      pc      = 32'h0;
      brkEn   = 1'b1;
      brkPc   = 32'h10;
      btnRun  = 1'b1;
      waitState(stRun, 20, ok);
      btnRun = 1'b0;
      waitState(stBrk, 60, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL brk_enter got=%0d want=%0d", stateO, stBrk); end
      checks++; if (atBrk !== 1'b1) begin failures++; $display("[TB] FAIL brk_at_brk got=%b want=1", atBrk); end
      checks++; if (instrCount !== 32'd4) begin failures++; $display("[TB] FAIL brk_count got=%0d want=4", instrCount); end
      checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL brk_halted got=%b want=1", halted); end
      repeat (10) stepCycle();
      checks++; if (stateO !== stBrk || instrCount !== 32'd4) begin failures++; $display("[TB] FAIL brk_hold got=%0d/%0d want=%0d/4", stateO, instrCount, stBrk); end
      btnRun = 1'b1;
      waitState(stRun, 20, ok);
      btnRun = 1'b0;
      checks++; if (!ok) begin failures++; $display("[TB] FAIL brk_resume got=%0d want=%0d", stateO, stRun); end
      waitState(stBrk, 60, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL brk_reenter got=%0d want=%0d", stateO, stBrk); end
      checks++; if (instrCount !== 32'd12) begin failures++; $display("[TB] FAIL brk_count2 got=%0d want=12", instrCount); end
      pcTrack = 1'b0;
      brkEn   = 1'b0;
   endtask

   task automatic test_reset_midrun();
      bit ok;
      int p0;
      doReset();
      pc = 32'h100;
      btnRun = 1'b1;
      waitState(stRun, 20, ok);
      btnRun = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (cpuEn === 1'b1 && instrCount !== 32'd0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok) begin failures++; $display("[TB] FAIL midrun_pulse got=%0d want=nonzero", instrCount); end
      reset = 1'b1;
      #1;
      checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL midrun_cpu_en got=%b want=0", cpuEn); end
      checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL midrun_halted got=%b want=1", halted); end
      checks++; if (instrCount !== 32'd0) begin failures++; $display("[TB] FAIL midrun_count got=%0d want=0", instrCount); end
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL midrun_state got=%0d want=%0d", stateO, stHalt); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      lastEn = 1'b0;
      p0 = pulses;
      repeat (10) stepCycle();
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL postreset_state got=%0d want=%0d", stateO, stHalt); end
      checks++; if (pulses != p0) begin failures++; $display("[TB] FAIL postreset_pulses got=%0d want=%0d", pulses - p0, 0); end
   endtask

   task automatic test_wrap();
      bit ok;
      doReset();
      force dut.instr_count_q = 32'hFFFF_FFFF;
      stepCycle();
      release dut.instr_count_q;
      #1;
      checks++; if (instrCount !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_preload got=%h want=ffffffff", instrCount); end
      btnStep = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (cpuEn === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      btnStep = 1'b0;
      stepCycle();
      checks++; if (!ok) begin failures++; $display("[TB] FAIL wrap_step got=%b want=1", cpuEn); end
      checks++; if (instrCount !== 32'd0) begin failures++; $display("[TB] FAIL wrap_count got=%h want=00000000", instrCount); end
      checks++; if (stateO !== stHalt) begin failures++; $display("[TB] FAIL wrap_state got=%0d want=%0d", stateO, stHalt); end
      repeat (10) stepCycle();
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_bounce();
      test_run_cadence();
      test_simultaneous();
      test_breakpoint();
      test_reset_midrun();
      test_wrap();
      checks++; if (consec != 0) begin failures++; $display("[TB] FAIL back_to_back_en got=%0d want=0", consec); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/proc_step_ctrl.md
# proc_step_ctrl

Execution controller for the single-cycle Proyecto2 processor core. It produces a one-cycle-wide clock enable `cpu_en` that gates every architectural update (PC, register file, data memory), so the 16-register LED view can be inspected on the board. Supported modes are halt, single-step, slow continuous run and stop-on-PC-breakpoint. It sits between the board buttons/switches and the processor, in the same 50 MHz `clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level (20 ms at 50 MHz).
- `RATE_DIV`, default 5_000_000: cycles between enables in RUN; legal range ≥1; 1 = every cycle.

Ports:
- `clk` in 1: system clock, 50 MHz, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `btn_step` in 1: raw step button, asynchronous, active-high.
- `btn_run` in 1: raw run/stop toggle button, asynchronous, active-high.
- `brk_en` in 1: breakpoint enable switch, quasi-static; sampled directly.
- `brk_pc` in 32: breakpoint address.
- `pc` in 32: current processor PC, i.e. the instruction that the next `cpu_en` executes.
- `cpu_en` out 1: processor clock enable, single-cycle pulse.
- `halted` out 1: 1 in every state except RUN.
- `at_brk` out 1: 1 in state BRK.
- `state` out 2: encoded FSM state for the LEDs.
- `instr_count` out 32: number of `cpu_en` pulses issued; wraps at 2^32.

## Operation
- Each button passes through a 2-FF synchronizer and then a debouncer. The debouncer accepts a new level only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples. A 0→1 transition of the accepted level gives a 1-cycle `*_press` pulse. Release gives no pulse.
- FSM states (package enum): HALT=0, STEP=1, RUN=2, BRK=3.
  - HALT: `run_press` → RUN. Otherwise `step_press` → STEP.
  - STEP: `cpu_en`=1 for exactly this one cycle, then → HALT unconditionally. Presses arriving in STEP are dropped.
  - RUN: a divider counts 0..RATE_DIV-1 and is cleared on entry. At `div == RATE_DIV-1` a tick occurs:
    - if `brk_en && pc == brk_pc && !skip_brk`, then → BRK and no enable is issued;
    - otherwise `cpu_en`=1 and `skip_brk` is cleared.
    - `run_press` → HALT. It has priority over a same-cycle tick or breakpoint, and no enable is issued in that cycle.
    - `step_press` is ignored.
  - BRK: `run_press` → RUN with `skip_brk`=1, so the breakpoint instruction executes once. Otherwise `step_press` → STEP.
- When both presses occur in the same cycle, run wins in HALT and BRK.
- `cpu_en` is asserted combinationally from state/tick (STEP state, or the RUN tick without breakpoint/run_press). It is never high for 2 consecutive cycles unless RATE_DIV=1 in RUN.
- `instr_count` increments on every cycle with `cpu_en`=1. It rolls over 0xFFFF_FFFF → 0.

## Timing
- Reset values: state=HALT, `cpu_en`=0, `halted`=1, `at_brk`=0, `instr_count`=0, divider=0, `skip_brk`=0, synchronizers/debounce counters/accepted levels=0.
- Reset asserted mid-operation forces these values immediately, with no enable glitch. After deassertion the FSM is in HALT.
- Raw button rise sampled at edge 0:
  - synchronizer output is 1 after edge 2;
  - `*_press` is high in the cycle after the DEBOUNCE_CYCLES-th stable sample;
  - the state changes at the next edge.
- Step latency: `cpu_en` is high in the first cycle after `step_press`, for exactly one cycle.
- RUN entry at edge E: the first tick is at cycle E+RATE_DIV-1 (cycle E = div 0). Subsequent ticks occur every RATE_DIV cycles.
- A breakpoint comparison uses the `pc` present in the tick cycle.

## Structure
- `proc_ctrl_pkg`: `ctrl_state_t` enum (HALT/STEP/RUN/BRK, 2-bit).
- Sub-module `btn_debounce` (synchronizer, counter, accepted level, rise pulse), parameterized by DEBOUNCE_CYCLES, instantiated twice.
- The top holds the FSM, divider, `skip_brk` and `instr_count`.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4 and RATE_DIV=3.
- Bounce: toggle `btn_step` every 2 cycles for 20 cycles, then hold it high for 10. Required: exactly one `cpu_en` pulse, `instr_count`=1, state back to HALT.
- Run cadence: press run, then hold `pc` ≠ `brk_pc`. Required: `cpu_en` pulses spaced exactly 3 cycles apart, first pulse 2 cycles after RUN entry. A second run press gives HALT and pulses stop; no pulse in the stop cycle.
- Breakpoint: `brk_en`=1, `brk_pc`=0x10, `pc` steps 0x0, 0x4, …. Required: BRK is entered when `pc`=0x10, `at_brk`=1, `instr_count`=4. A run press then executes 0x10 (count 5) and continues. Reaching 0x10 again re-stops.
- Simultaneous: assert `step_press` and `run_press` in the same HALT cycle. Required: RUN, no STEP pulse. In RUN, `run_press` coincident with a tick gives HALT and `cpu_en` stays 0.
- Reset: assert `reset` mid-RUN between edges. Required: immediate `cpu_en`=0, `halted`=1, `instr_count`=0; after release, the state stays HALT with no spurious enable.
- Wrap: force `instr_count` to 0xFFFF_FFFF, then step. Required: `instr_count` reads 0.
